beat_count_stacked: RTL and testbench
=====================================

Name: beat_count_stacked

Overview:
- Consumes the 3-bit sample word from the stacked odometer's 3-bit shift sampler.
- Detects deglitched rising beats of the sampled oscillator and counts them over a programmable window of CLK cycles.
- Presents the result to the readout logic through a VALID/ACK handshake.
- Sits directly downstream of the sampler, in the same CLK domain.

Parameters:
- CNT_W, 12, width of beat count and COUNT_OUT.
- WIN_W, 16, width of WINDOW_LEN and the internal window counter.

Ports:
- CLK  input  1  sample/system clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SAMPLE_IN  input  [0:2]  sampler word; bit 0 newest, bit 2 oldest.
- WINDOW_LEN  input  WIN_W  measurement length in CLK cycles; sampled on START accept.
- START  input  1  request a measurement; honoured only in IDLE.
- ACK  input  1  readout acknowledge; honoured only in DONE.
- COUNT_OUT  output  CNT_W  beat count; stable while VALID=1.
- VALID  output  1  result available.
- BUSY  output  1  high in ARM and COUNT.
- OVF  output  1  count saturated during the current/last measurement.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE.
  - COUNT_OUT=0, VALID=0, BUSY=0, OVF=0.
  - Window and flush counters cleared.
  - Takes effect mid-measurement with no result emitted.
- Beat detect (combinational):
  - BEAT = (SAMPLE_IN[0]==1) && (SAMPLE_IN[1]==1) && (SAMPLE_IN[2]==0).
  - This pattern means two consecutive high samples after a low.
  - A single-cycle high pulse (100, 010, 001) never produces BEAT.
- States: IDLE, ARM, COUNT, DONE.
- IDLE:
  - START=1 -> latch WINDOW_LEN.
  - COUNT_OUT<=0, OVF<=0, flush counter<=0.
  - Next state ARM.
- ARM:
  - Lasts exactly 3 cycles to flush stale sampler contents.
  - BEAT is ignored.
  - After the 3rd cycle: if latched length==0 -> DONE (COUNT_OUT=0); else -> COUNT.
- COUNT:
  - Lasts exactly latched WINDOW_LEN cycles.
  - Each cycle with BEAT=1: COUNT_OUT increments by 1.
  - At all-ones, COUNT_OUT holds and OVF<=1 (sticky until the next START accept).
  - BEAT on the final COUNT cycle is counted.
  - Next state DONE.
- DONE:
  - VALID=1 (registered, asserted the first DONE cycle).
  - COUNT_OUT and OVF frozen.
  - ACK=1 -> IDLE; VALID=0 from the next cycle; COUNT_OUT keeps its value until the next START accept.
- BUSY=1 exactly in ARM and COUNT.
- START outside IDLE is ignored (not queued).
- ACK outside DONE is ignored.
- START and ACK together in DONE: ACK taken, START dropped; the requester must reassert START in IDLE.
- WINDOW_LEN changes after START accept have no effect.
- Latency: VALID rises 3+WINDOW_LEN+1 cycles after the START-accept edge.
- Arithmetic is unsigned; no wrap-around of COUNT_OUT.

Test Plan:
- Reset/idle:
  - Stimulus: assert RST_N=0 with SAMPLE_IN toggling, then release and hold START=0 for 20 cycles.
  - Required: COUNT_OUT=0, VALID=0, BUSY=0, OVF=0 throughout.
- Basic count:
  - Stimulus: WINDOW_LEN=10, START; drive SAMPLE_IN=110 on COUNT cycles 2 and 6 and on an ARM cycle; 000 otherwise.
  - Required: BUSY=1 for 13 cycles, then VALID=1, COUNT_OUT=2, OVF=0.
  - Then ACK -> VALID=0 next cycle, COUNT_OUT stays 2.
- Glitch reject:
  - Stimulus: WINDOW_LEN=8; drive the sequence 100, 010, 001, 000 twice, then 100, 110, 011, 001.
  - Required: COUNT_OUT=1.
- Saturation:
  - Stimulus: CNT_W=4, WINDOW_LEN=20, SAMPLE_IN=110 every COUNT cycle.
  - Required: COUNT_OUT=15, OVF=1.
  - A following START with no beats -> COUNT_OUT=0, OVF=0.
- Zero window / handshake:
  - Stimulus: WINDOW_LEN=0, START.
  - Required: VALID after 4 cycles, COUNT_OUT=0.
  - START pulsed in ARM/DONE and ACK pulsed in IDLE/COUNT have no effect.
  - START+ACK together in DONE -> IDLE, no new measurement.
- Reset mid-operation:
  - Stimulus: assert RST_N=0 during COUNT with beats present.
  - Required: all outputs 0 immediately (asynchronous).
  - After release, the block stays IDLE until START.

Source files
------------

// File: rtl/beat_count_stacked.sv
// Beat counter for the stacked odometer: detects deglitched rising beats in the
// 3-bit sampler word and counts them over a programmable window of CLK cycles,
// handing the result to readout through a VALID/ACK handshake.
module beat_count_stacked #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned WIN_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [0:2]       SAMPLE_IN,
    input  logic [WIN_W-1:0] WINDOW_LEN,
    input  logic             START,
    input  logic             ACK,
    output logic [CNT_W-1:0] COUNT_OUT,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVF
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Index of the last ARM cycle (three flush cycles: 0, 1, 2).
    localparam logic [1:0] FLUSH_LAST = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_q;
    logic [1:0]       state_nxt;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] len_nxt;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_nxt;
    logic [1:0]       flush_q;
    logic [1:0]       flush_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             ovf_nxt;
    logic             valid_nxt;
    logic             busy_nxt;
    logic             beat_c;

    // Rising beat: two consecutive high samples following a low one.
    assign beat_c = SAMPLE_IN[0] & SAMPLE_IN[1] & ~SAMPLE_IN[2];

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state, counter and output computation.
    always_comb begin
        state_nxt = state_q;
        len_nxt   = len_q;
        win_nxt   = win_q;
        flush_nxt = flush_q;
        count_nxt = COUNT_OUT;
        ovf_nxt   = OVF;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    len_nxt   = WINDOW_LEN;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                    flush_nxt = '0;
                    win_nxt   = '0;
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                // Sampler contents are stale here, so beats are ignored.
                if (flush_q == FLUSH_LAST) begin
                    win_nxt   = '0;
                    state_nxt = (len_q == '0) ? S_DONE : S_COUNT;
                end else begin
                    flush_nxt = flush_q + 2'd1;
                end
            end
            S_COUNT: begin
                if (beat_c) begin
                    if (COUNT_OUT == CNT_MAX) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        count_nxt = COUNT_OUT + CNT_W'(1);
                    end
                end
                if (win_q == (len_q - WIN_W'(1))) begin
                    state_nxt = S_DONE;
                end else begin
                    win_nxt = win_q + WIN_W'(1);
                end
            end
            S_DONE: begin
                // START in the same cycle as ACK is dropped, not queued.
                if (ACK) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        valid_nxt = (state_nxt == S_DONE);
        busy_nxt  = (state_nxt == S_ARM) || (state_nxt == S_COUNT);
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_q     <= '0;
            win_q     <= '0;
            flush_q   <= '0;
            COUNT_OUT <= '0;
            OVF       <= 1'b0;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            len_q     <= len_nxt;
            win_q     <= win_nxt;
            flush_q   <= flush_nxt;
            COUNT_OUT <= count_nxt;
            OVF       <= ovf_nxt;
            VALID     <= valid_nxt;
            BUSY      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_beat_count_stacked.sv
// Directed bench for beat_count_stacked: a default-width instance plus a
// 4-bit-count instance for saturation, sharing all inputs.
module tb_beat_count_stacked;

    logic        CLK;
    logic        RST_N;
    logic [0:2]  SAMPLE_IN;
    logic [15:0] WINDOW_LEN;
    logic        START;
    logic        ACK;

    logic [11:0] cnt;
    logic        valid, busy, ovf;
    logic [3:0]  cnt4;
    logic        valid4, busy4, ovf4;

    int total = 0;
    int bad   = 0;

    beat_count_stacked dut (
        .CLK(CLK), .RST_N(RST_N), .SAMPLE_IN(SAMPLE_IN), .WINDOW_LEN(WINDOW_LEN),
        .START(START), .ACK(ACK), .COUNT_OUT(cnt), .VALID(valid), .BUSY(busy), .OVF(ovf)
    );

    beat_count_stacked #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .SAMPLE_IN(SAMPLE_IN), .WINDOW_LEN(WINDOW_LEN),
        .START(START), .ACK(ACK), .COUNT_OUT(cnt4), .VALID(valid4), .BUSY(busy4), .OVF(ovf4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Request a measurement from IDLE; returns in the first ARM cycle.
    task automatic start_meas(input logic [15:0] len);
        WINDOW_LEN = len;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    logic [0:2] gl [12];

    initial begin
        gl = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000,
               3'b100, 3'b110, 3'b011, 3'b001};

        RST_N = 1'b0;
        SAMPLE_IN = 3'b000;
        WINDOW_LEN = 16'd0;
        START = 1'b0;
        ACK = 1'b0;

        // Reset with sampler toggling, then idle for 20 cycles.
        for (int i = 0; i < 4; i++) begin
            SAMPLE_IN = (i % 2 == 0) ? 3'b110 : 3'b000;
            tick();
            chk("rst_hold", {cnt, valid, busy, ovf}, 0);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            SAMPLE_IN = (i % 3 == 0) ? 3'b110 : 3'b000;
            tick();
            chk("idle", {cnt, valid, busy, ovf}, 0);
        end

        // Basic count: beats on an ARM cycle (ignored) and COUNT cycles 2 and 6.
        SAMPLE_IN = 3'b000;
        start_meas(16'd10);
        WINDOW_LEN = 16'd3;
        for (int c = 0; c < 13; c++) begin
            SAMPLE_IN = (c == 1 || c == 4 || c == 8) ? 3'b110 : 3'b000;
            chk("basic_busy", busy, 1);
            chk("basic_novalid", valid, 0);
            tick();
        end
        SAMPLE_IN = 3'b000;
        chk("basic_valid", valid, 1);
        chk("basic_busy_off", busy, 0);
        chk("basic_cnt", cnt, 2);
        chk("basic_ovf", ovf, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("basic_ack_valid", valid, 0);
        chk("basic_ack_cnt", cnt, 2);

        // Glitch reject: only the 110 pattern counts.
        start_meas(16'd8);
        for (int c = 0; c < 12; c++) begin
            SAMPLE_IN = gl[c];
            tick();
        end
        SAMPLE_IN = 3'b000;
        chk("glitch_valid", valid, 1);
        chk("glitch_cnt", cnt, 1);
        chk("glitch_cnt4", cnt4, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;

        // Saturation on the 4-bit instance: 20 beats.
        start_meas(16'd20);
        chk("sat_clr", cnt4, 0);
        SAMPLE_IN = 3'b110;
        for (int c = 0; c < 23; c++) tick();
        SAMPLE_IN = 3'b000;
        chk("sat_valid4", valid4, 1);
        chk("sat_cnt4", cnt4, 15);
        chk("sat_ovf4", ovf4, 1);
        chk("sat_cnt12", cnt, 20);
        chk("sat_ovf12", ovf, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("sat_ovf4_held", ovf4, 1);
        start_meas(16'd5);
        chk("resat_ovf_clr", ovf4, 0);
        for (int c = 0; c < 8; c++) tick();
        chk("resat_valid4", valid4, 1);
        chk("resat_cnt4", cnt4, 0);
        chk("resat_ovf4", ovf4, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;

        // Zero window: VALID on the 4th edge after START is raised.
        WINDOW_LEN = 16'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("zero_busy1", busy, 1);
        chk("zero_v1", valid, 0);
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("zero_v2", valid, 0);
        chk("zero_busy2", busy, 1);
        tick();
        chk("zero_valid", valid, 1);
        chk("zero_busy_off", busy, 0);
        chk("zero_cnt", cnt, 0);
        START = 1'b1;
        tick();
        chk("done_start_ign", {valid, busy}, 2);
        ACK = 1'b1;
        tick();
        START = 1'b0;
        ACK = 1'b0;
        chk("start_ack_idle", {valid, busy}, 0);
        tick();
        chk("no_new_meas", {valid, busy}, 0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("idle_ack_ign", {valid, busy}, 0);

        // ACK during COUNT is ignored.
        start_meas(16'd4);
        for (int c = 0; c < 7; c++) begin
            ACK = (c == 4);
            SAMPLE_IN = (c == 5) ? 3'b110 : 3'b000;
            tick();
        end
        ACK = 1'b0;
        SAMPLE_IN = 3'b000;
        chk("cnt_ack_valid", valid, 1);
        chk("cnt_ack_cnt", cnt, 1);
        tick();
        tick();
        chk("done_hold", valid, 1);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;

        // Asynchronous reset in the middle of COUNT.
        start_meas(16'd10);
        for (int c = 0; c < 6; c++) begin
            SAMPLE_IN = (c % 2 == 0) ? 3'b110 : 3'b000;
            tick();
        end
        chk("mid_busy", busy, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst", {cnt, valid, busy, ovf}, 0);
        chk("mid_rst4", {cnt4, valid4, busy4, ovf4}, 0);
        tick();
        RST_N = 1'b1;
        for (int c = 0; c < 10; c++) begin
            SAMPLE_IN = (c % 2 == 0) ? 3'b110 : 3'b000;
            tick();
            chk("post_rst_idle", {cnt, valid, busy, ovf}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
